ps2_cmd_sequencer: RTL and testbench

- Sits between the PS/2 receiver byte stream and the Tetris processor's input register.
- Parses multi-byte scan-code sequences (E0 extended prefix, F0 break prefix) into game commands.
- Generates auto-repeat for held movement keys and suppresses the keyboard's own typematic repeats.
- Buffers commands in a small FIFO drained via a valid/ready handshake.

---
 rtl/ps2_cmd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ps2_cmd_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_sequencer.sv
// Purpose: turn PS/2 scan-code bytes into Tetris commands with auto-repeat, queued in a small FIFO.
// Latency: final byte strobe at cycle N -> cmd_valid at N+2 (parse register, then FIFO write).
// Backpressure: cmd/cmd_valid drained by cmd_ready; a push into a full FIFO with no pop is dropped and sets sticky overflow.
//
// Ports:
//   clk, resetn                 clock, async active-low reset
//   ps2_out, ps2_key_pressed    received byte and its one-cycle strobe
//   cmd_ready                   consumer accepts head command
//   cmd, cmd_valid              head command (0 when empty), FIFO non-empty
//   overflow                    sticky drop indicator
module ps2_cmd_sequencer #(
    parameter int DELAY_CYCLES = 12500000,
    parameter int RATE_CYCLES  = 2500000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] ps2_out,
    input  logic       ps2_key_pressed,
    input  logic       cmd_ready,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic       overflow
);

    localparam int CNT_MAX = (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(RATE_CYCLES - 1);
    localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_LEFT   = 3'd1;
    localparam logic [2:0] CMD_RIGHT  = 3'd2;
    localparam logic [2:0] CMD_DOWN   = 3'd3;
    localparam logic [2:0] CMD_ROTATE = 3'd4;
    localparam logic [2:0] CMD_DROP   = 3'd5;
    localparam logic [2:0] CMD_PAUSE  = 3'd6;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parseState_t;

    function automatic logic [2:0] mapKey(input logic [7:0] code, input logic ext);
        logic [2:0] c;
        c = CMD_NONE;
        if (ext) begin
            case (code)
                8'h6B:   c = CMD_LEFT;
                8'h74:   c = CMD_RIGHT;
                8'h72:   c = CMD_DOWN;
                8'h75:   c = CMD_ROTATE;
                default: c = CMD_NONE;
            endcase
        end
        if (code == 8'h29) c = CMD_DROP;
        if (code == 8'h76) c = CMD_PAUSE;
        return c;
    endfunction

    parseState_t     parseState;
    logic            pendVld;
    logic [2:0]      pendCmd;
    logic [2:0]      heldKey;
    logic [CW-1:0]   repCnt;
    logic            firstDone;

    logic [2:0]      fifoMem [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [AW:0]     fifoCount;

    logic            byteMake;
    logic            byteBrk;
    logic            byteExt;
    logic [2:0]      byteCmd;
    logic            repeatable;
    logic            typematic;
    logic            tickDue;
    logic            pushVld;
    logic [2:0]      pushCmd;
    logic            popEn;
    logic            fifoFull;
    logic            wrEn;

    // Classify the strobed byte against the current prefix state.
    always_comb begin
        byteMake = 1'b0;
        byteBrk  = 1'b0;
        byteExt  = 1'b0;
        if (ps2_key_pressed) begin
            case (parseState)
                IDLE:    byteMake = (ps2_out != 8'hE0) && (ps2_out != 8'hF0);
                EXT: begin
                    byteMake = (ps2_out != 8'hE0) && (ps2_out != 8'hF0);
                    byteExt  = 1'b1;
                end
                BRK:     byteBrk = 1'b1;
                EXT_BRK: begin
                    byteBrk = 1'b1;
                    byteExt = 1'b1;
                end
                default: byteMake = 1'b0;
            endcase
        end
    end

    assign byteCmd    = mapKey(ps2_out, byteExt);
    assign repeatable = (byteCmd == CMD_LEFT) || (byteCmd == CMD_RIGHT) || (byteCmd == CMD_DOWN);
    // A make of the key already held is the keyboard's own typematic repeat.
    assign typematic  = byteMake && repeatable && (byteCmd == heldKey);

    assign tickDue  = (heldKey != CMD_NONE) && (repCnt == (firstDone ? RATE_LAST : DELAY_LAST));
    // Byte-derived command wins the single enqueue slot; the tick waits.
    assign pushVld  = pendVld || tickDue;
    assign pushCmd  = pendVld ? pendCmd : heldKey;

    assign cmd_valid = (fifoCount != '0);
    assign cmd       = cmd_valid ? fifoMem[rdPtr] : CMD_NONE;
    assign popEn     = cmd_valid && cmd_ready;
    assign fifoFull  = (fifoCount == FIFO_FULL);
    assign wrEn      = pushVld && (!fifoFull || popEn);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parseState <= IDLE;
            pendVld    <= 1'b0;
            pendCmd    <= CMD_NONE;
            heldKey    <= CMD_NONE;
            repCnt     <= '0;
            firstDone  <= 1'b0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifoCount  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (ps2_key_pressed) begin
                case (parseState)
                    IDLE: begin
                        if (ps2_out == 8'hE0)      parseState <= EXT;
                        else if (ps2_out == 8'hF0) parseState <= BRK;
                    end
                    EXT: begin
                        if (ps2_out == 8'hF0)      parseState <= EXT_BRK;
                        else if (ps2_out != 8'hE0) parseState <= IDLE;
                    end
                    default: parseState <= IDLE;
                endcase
            end

            pendVld <= byteMake && (byteCmd != CMD_NONE) && !typematic;
            pendCmd <= byteCmd;

            if (byteMake && repeatable && !typematic) begin
                heldKey   <= byteCmd;
                repCnt    <= '0;
                firstDone <= 1'b0;
            end else if (byteBrk && (heldKey != CMD_NONE) && (byteCmd == heldKey)) begin
                heldKey   <= CMD_NONE;
                repCnt    <= '0;
                firstDone <= 1'b0;
            end else if (heldKey != CMD_NONE) begin
                if (tickDue) begin
                    // Hold at the terminal count until the slot is free.
                    if (!pendVld) begin
                        repCnt    <= '0;
                        firstDone <= 1'b1;
                    end
                end else begin
                    repCnt <= repCnt + CW'(1);
                end
            end

            if (wrEn)  wrPtr <= wrPtr + AW'(1);
            if (popEn) rdPtr <= rdPtr + AW'(1);
            if (wrEn && !popEn)      fifoCount <= fifoCount + (AW + 1)'(1);
            else if (!wrEn && popEn) fifoCount <= fifoCount - (AW + 1)'(1);
            if (pushVld && fifoFull && !popEn) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) fifoMem[wrPtr] <= pushCmd;
    end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
module tb_ps2_cmd_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] ps2_out;
    logic       ps2_key_pressed;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int logCmd [$];
    int logCyc [$];

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         n;
        int         expCmd;
    } vec_t;

    typedef struct {
        int expCmd;
        int offset;
    } beat_t;

    ps2_cmd_sequencer #(
        .DELAY_CYCLES(20),
        .RATE_CYCLES (5),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ps2_out        (ps2_out),
        .ps2_key_pressed(ps2_key_pressed),
        .cmd_ready      (cmd_ready),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Every accepted beat is logged with the index of the edge that popped it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (resetn && cmd_valid && cmd_ready) begin
            logCmd.push_back(int'(cmd));
            logCyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int getCmd(input int i);
        return (i < logCmd.size()) ? logCmd[i] : -1;
    endfunction

    function automatic int getCyc(input int i);
        return (i < logCyc.size()) ? logCyc[i] : -1;
    endfunction

    task automatic clearLog();
        logCmd.delete();
        logCyc.delete();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe one byte; returns the index of the edge that sampled it.
    task automatic sendByte(input logic [7:0] b, output int edgeCyc);
        @(negedge clk);
        ps2_out = b;
        ps2_key_pressed = 1'b1;
        @(negedge clk);
        ps2_key_pressed = 1'b0;
        edgeCyc = cyc;
    endtask

    // Strobe one byte so that it is sampled by edge number target.
    task automatic sendAt(input logic [7:0] b, input int target);
        while (cyc < target - 1) @(negedge clk);
        check("schedule", cyc, target - 1);
        ps2_out = b;
        ps2_key_pressed = 1'b1;
        @(negedge clk);
        ps2_key_pressed = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        vec_t  vecs [9];
        beat_t beats3 [8];
        int    drain4 [4];
        int    drain5 [5];
        int    e;
        int    k;
        int    b;
        int    s;
        int    expCyc [$];

        vecs[0] = '{8'hE0, 8'h72, 8'h00, 2, 3};
        vecs[1] = '{8'hE0, 8'h75, 8'h00, 2, 4};
        vecs[2] = '{8'h29, 8'h00, 8'h00, 1, 5};
        vecs[3] = '{8'h76, 8'h00, 8'h00, 1, 6};
        vecs[4] = '{8'h6B, 8'h00, 8'h00, 1, 0};
        vecs[5] = '{8'h75, 8'h00, 8'h00, 1, 0};
        vecs[6] = '{8'hE0, 8'hE0, 8'h75, 3, 4};
        vecs[7] = '{8'hF0, 8'h29, 8'h00, 2, 0};
        vecs[8] = '{8'hE0, 8'h11, 8'h00, 2, 0};

        beats3 = '{'{1, 2}, '{1, 21}, '{1, 26}, '{5, 31}, '{1, 32}, '{1, 37}, '{1, 42}, '{1, 47}};
        drain4 = '{5, 6, 4, 5};
        drain5 = '{5, 6, 5, 6, 5};

        resetn          = 1'b0;
        ps2_out         = 8'h00;
        ps2_key_pressed = 1'b0;
        cmd_ready       = 1'b1;
        waitCycles(3);
        check("reset cmd_valid", int'(cmd_valid), 0);
        check("reset cmd", int'(cmd), 0);
        check("reset overflow", int'(overflow), 0);
        resetn = 1'b1;
        waitCycles(2);

        // Single LEFT make: one beat exactly two edges after the final strobe.
        clearLog();
        sendByte(8'hE0, s);
        sendAt(8'h6B, s + 3);
        k = s + 3;
        waitCycles(4);
        check("left count", logCmd.size(), 1);
        check("left cmd", getCmd(0), 1);
        check("left latency", getCyc(0), k + 2);
        check("left drained", int'(cmd_valid), 0);
        sendByte(8'hE0, e);
        sendByte(8'hF0, e);
        sendByte(8'h6B, e);
        waitCycles(40);
        check("left no repeat after break", logCmd.size(), 1);

        // Key map vectors.
        foreach (vecs[i]) begin
            clearLog();
            if (vecs[i].n > 0) sendByte(vecs[i].b0, e);
            if (vecs[i].n > 1) sendByte(vecs[i].b1, e);
            if (vecs[i].n > 2) sendByte(vecs[i].b2, e);
            waitCycles(4);
            check($sformatf("vec%0d count", i), logCmd.size(), (vecs[i].expCmd != 0) ? 1 : 0);
            if (vecs[i].expCmd != 0) check($sformatf("vec%0d cmd", i), getCmd(0), vecs[i].expCmd);
            if (vecs[i].expCmd >= 1 && vecs[i].expCmd <= 3) begin
                sendByte(8'hE0, e);
                sendByte(8'hF0, e);
                sendByte(vecs[i].b1, e);
                waitCycles(3);
            end
        end

        // RIGHT held: first repeat DELAY edges after the make, then every RATE.
        clearLog();
        sendByte(8'hE0, e);
        sendByte(8'h74, k);
        waitCycles(50);
        sendByte(8'hE0, e);
        sendByte(8'hF0, e);
        sendByte(8'h74, b);
        waitCycles(30);
        expCyc.delete();
        expCyc.push_back(k + 2);
        for (int t = k + 20; t <= b; t += 5) expCyc.push_back(t + 1);
        check("right count", logCmd.size(), expCyc.size());
        foreach (expCyc[i]) begin
            check($sformatf("right%0d cmd", i), getCmd(i), 2);
            check($sformatf("right%0d cyc", i), getCyc(i), expCyc[i]);
        end

        // LEFT held with typematic makes, then DROP colliding with a repeat tick.
        clearLog();
        sendByte(8'hE0, e);
        sendByte(8'h6B, k);
        sendAt(8'hE0, k + 8);
        sendAt(8'h6B, k + 10);
        sendAt(8'hE0, k + 22);
        sendAt(8'h6B, k + 24);
        sendAt(8'h29, k + 29);
        sendAt(8'hE0, k + 43);
        sendAt(8'hF0, k + 45);
        sendAt(8'h6B, k + 47);
        waitCycles(30);
        check("typematic count", logCmd.size(), 8);
        foreach (beats3[i]) begin
            check($sformatf("typematic%0d cmd", i), getCmd(i), beats3[i].expCmd);
            check($sformatf("typematic%0d cyc", i), getCyc(i), k + beats3[i].offset);
        end

        // Overflow: fifth command dropped, order of the rest preserved.
        pulseReset();
        clearLog();
        cmd_ready = 1'b0;
        sendByte(8'h29, e);
        sendByte(8'h76, e);
        sendByte(8'hE0, e);
        sendByte(8'h75, e);
        sendByte(8'h29, e);
        sendByte(8'h76, e);
        waitCycles(3);
        check("ovf flag", int'(overflow), 1);
        check("ovf head valid", int'(cmd_valid), 1);
        check("ovf head cmd", int'(cmd), 5);
        cmd_ready = 1'b1;
        waitCycles(8);
        cmd_ready = 1'b0;
        check("ovf drain count", logCmd.size(), 4);
        foreach (drain4[i]) check($sformatf("ovf drain%0d", i), getCmd(i), drain4[i]);
        check("ovf sticky", int'(overflow), 1);
        check("ovf empty", int'(cmd_valid), 0);

        // Full FIFO with simultaneous push and pop: nothing lost.
        pulseReset();
        check("reset clears ovf", int'(overflow), 0);
        clearLog();
        sendByte(8'h29, e);
        sendByte(8'h76, e);
        sendByte(8'h29, e);
        sendByte(8'h76, e);
        waitCycles(3);
        s = cyc + 2;
        sendAt(8'h29, s);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        waitCycles(2);
        check("pushpop popped", logCmd.size(), 1);
        check("pushpop popped cyc", getCyc(0), s + 1);
        check("pushpop ovf", int'(overflow), 0);
        check("pushpop head", int'(cmd), 6);
        cmd_ready = 1'b1;
        waitCycles(8);
        check("pushpop total", logCmd.size(), 5);
        foreach (drain5[i]) check($sformatf("pushpop drain%0d", i), getCmd(i), drain5[i]);
        check("pushpop ovf end", int'(overflow), 0);

        // Reset mid-sequence discards the prefix and clears the FIFO.
        cmd_ready = 1'b0;
        sendByte(8'h29, e);
        sendByte(8'hE0, e);
        sendByte(8'hF0, e);
        waitCycles(2);
        check("pre-reset valid", int'(cmd_valid), 1);
        resetn = 1'b0;
        #2;
        check("midreset cmd_valid", int'(cmd_valid), 0);
        check("midreset cmd", int'(cmd), 0);
        check("midreset overflow", int'(overflow), 0);
        @(negedge clk);
        resetn = 1'b1;
        sendByte(8'h6B, e);
        waitCycles(3);
        check("after reset 6B", int'(cmd_valid), 0);
        sendByte(8'hE0, e);
        pulseReset();
        sendByte(8'h75, e);
        waitCycles(3);
        check("after reset 75", int'(cmd_valid), 0);
        sendByte(8'hE0, e);
        sendByte(8'h75, e);
        waitCycles(3);
        check("ext 75 valid", int'(cmd_valid), 1);
        check("ext 75 cmd", int'(cmd), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
